// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: forwarding selects, stall causes
// and the multi-cycle scoreboard state type.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'b00,
        CAUSE_LOAD   = 2'b01,
        CAUSE_RAW    = 2'b10,
        CAUSE_STRUCT = 2'b11
    } stall_cause_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } sb_state_e;

    // MEM holds the younger result, so it wins over WB.
    function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
        if (mem_hit)
            return FWD_MEM;
        else if (wb_hit)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_mul_scoreboard.sv
// Tracks one outstanding multi-cycle operation: busy window, done pulse and
// the destination register it will write.
//   state   | meaning
//   ST_IDLE | no operation outstanding
//   ST_BUSY | operation in flight, cnt_q counts down to zero
//   ST_DONE | result written back this cycle, new issue may be accepted
module mul_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MUL_LAT    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_i,
    input  logic [REG_ADDR_W-1:0] issue_dst_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [REG_ADDR_W-1:0] pending_dst_o
);

    localparam int CNT_BITS = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(MUL_LAT - 1);

    sb_state_e             state_q;
    logic [CNT_BITS-1:0]   cnt_q;
    logic [REG_ADDR_W-1:0] dst_q;
    logic                  busy_q;
    logic                  done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dst_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (issue_i) begin
                        state_q <= ST_BUSY;
                        cnt_q   <= CNT_INIT;
                        dst_q   <= issue_dst_i;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign pending_dst_o = dst_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: EX operand forwarding, load-use and multi-cycle interlocks,
// and a saturating stalled-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int MUL_LAT    = 4,
    parameter int CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] ID_src_addr,
    input  logic [NUM_SRC-1:0]            ID_src_valid,
    input  logic                          ID_mul_valid,
    input  logic [REG_ADDR_W-1:0]         ID_mul_dst,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] EX_src_addr,
    input  logic                          EX_MemRead,
    input  logic                          EX_RegWrite,
    input  logic [REG_ADDR_W-1:0]         EX_WriteRegister,
    input  logic                          MEM_RegWrite,
    input  logic                          WB_RegWrite,
    input  logic [REG_ADDR_W-1:0]         MEM_WriteRegister,
    input  logic [REG_ADDR_W-1:0]         WB_WriteRegister,
    output logic [2*NUM_SRC-1:0]          Forward,
    output logic                          stall,
    output logic                          flush_ex,
    output logic [1:0]                    stall_cause,
    output logic                          mul_busy,
    output logic                          mul_done,
    output logic [CNT_W-1:0]              stall_count
);

    logic                  load_use;
    logic                  raw_pend;
    logic                  struct_hz;
    logic                  mul_issue;
    logic [REG_ADDR_W-1:0] pending_dst;
    logic [CNT_W-1:0]      stall_count_q;

    always_comb begin
        Forward  = '0;
        load_use = 1'b0;
        raw_pend = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            Forward[2*i +: 2] = fwd_sel(
                MEM_RegWrite && (MEM_WriteRegister != '0) &&
                    (MEM_WriteRegister == EX_src_addr[i*REG_ADDR_W +: REG_ADDR_W]),
                WB_RegWrite && (WB_WriteRegister != '0) &&
                    (WB_WriteRegister == EX_src_addr[i*REG_ADDR_W +: REG_ADDR_W]));
            // r0 reads never interlock, which also makes a dst of 0 harmless.
            if (ID_src_valid[i] && (ID_src_addr[i*REG_ADDR_W +: REG_ADDR_W] != '0)) begin
                if (EX_MemRead && EX_RegWrite &&
                    (EX_WriteRegister == ID_src_addr[i*REG_ADDR_W +: REG_ADDR_W]))
                    load_use = 1'b1;
                if (mul_busy && (pending_dst == ID_src_addr[i*REG_ADDR_W +: REG_ADDR_W]))
                    raw_pend = 1'b1;
            end
        end
    end

    assign struct_hz = mul_busy && ID_mul_valid;
    assign stall     = load_use || raw_pend || struct_hz;
    assign flush_ex  = stall;
    assign mul_issue = ID_mul_valid && !stall;

    always_comb begin
        if (load_use)
            stall_cause = CAUSE_LOAD;
        else if (raw_pend)
            stall_cause = CAUSE_RAW;
        else if (struct_hz)
            stall_cause = CAUSE_STRUCT;
        else
            stall_cause = CAUSE_NONE;
    end

    mul_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W),
        .MUL_LAT    (MUL_LAT)
    ) u_mul_sb (
        .clk           (clk),
        .rst           (rst),
        .issue_i       (mul_issue),
        .issue_dst_i   (ID_mul_dst),
        .busy_o        (mul_busy),
        .done_o        (mul_done),
        .pending_dst_o (pending_dst)
    );

    always_ff @(posedge clk) begin
        if (rst)
            stall_count_q <= '0;
        else if (stall && (stall_count_q != '1))
            stall_count_q <= stall_count_q + 1'b1;
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stimulus pushes per-cycle expectations into a
// queue, a negedge monitor pops and compares them against the outputs.
module tb_hazard_ctrl;

    localparam int AW = 5;
    localparam int NS = 2;
    localparam int CW = 4;

    typedef struct packed {
        logic [3:0] fwd;
        logic       stall;
        logic [1:0] cause;
        logic       busy;
        logic       done;
        logic [3:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [NS*AW-1:0] ID_src_addr;
    logic [NS-1:0]    ID_src_valid;
    logic             ID_mul_valid;
    logic [AW-1:0]    ID_mul_dst;
    logic [NS*AW-1:0] EX_src_addr;
    logic             EX_MemRead, EX_RegWrite;
    logic [AW-1:0]    EX_WriteRegister;
    logic             MEM_RegWrite, WB_RegWrite;
    logic [AW-1:0]    MEM_WriteRegister, WB_WriteRegister;
    logic [2*NS-1:0]  Forward;
    logic             stall, flush_ex;
    logic [1:0]       stall_cause;
    logic             mul_busy, mul_done;
    logic [CW-1:0]    stall_count;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    logic [3:0] exp_cnt = '0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_ADDR_W (AW),
        .NUM_SRC    (NS),
        .MUL_LAT    (4),
        .CNT_W      (CW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ID_src_addr       (ID_src_addr),
        .ID_src_valid      (ID_src_valid),
        .ID_mul_valid      (ID_mul_valid),
        .ID_mul_dst        (ID_mul_dst),
        .EX_src_addr       (EX_src_addr),
        .EX_MemRead        (EX_MemRead),
        .EX_RegWrite       (EX_RegWrite),
        .EX_WriteRegister  (EX_WriteRegister),
        .MEM_RegWrite      (MEM_RegWrite),
        .WB_RegWrite       (WB_RegWrite),
        .MEM_WriteRegister (MEM_WriteRegister),
        .WB_WriteRegister  (WB_WriteRegister),
        .Forward           (Forward),
        .stall             (stall),
        .flush_ex          (flush_ex),
        .stall_cause       (stall_cause),
        .mul_busy          (mul_busy),
        .mul_done          (mul_done),
        .stall_count       (stall_count)
    );

    task automatic chk(input string nm, input string field, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%0h required=%0h", nm, field, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk(nm, "Forward",     32'(Forward),     32'(e.fwd));
            chk(nm, "stall",       32'(stall),       32'(e.stall));
            chk(nm, "flush_ex",    32'(flush_ex),    32'(e.stall));
            chk(nm, "stall_cause", 32'(stall_cause), 32'(e.cause));
            chk(nm, "mul_busy",    32'(mul_busy),    32'(e.busy));
            chk(nm, "mul_done",    32'(mul_done),    32'(e.done));
            chk(nm, "stall_count", 32'(stall_count), 32'(e.cnt));
        end
    end

    task automatic idle();
        rst = 1'b0;
        ID_src_addr = '0; ID_src_valid = '0; ID_mul_valid = 1'b0; ID_mul_dst = '0;
        EX_src_addr = '0; EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_WriteRegister = '0;
        MEM_RegWrite = 1'b0; WB_RegWrite = 1'b0; MEM_WriteRegister = '0; WB_WriteRegister = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = '0;
    endtask

    // One cycle: expectation for the current inputs, then advance past the edge.
    task automatic cyc(input string nm, input logic [3:0] fwd, input logic st,
                       input logic [1:0] cause, input logic busy, input logic done);
        exp_t e;
        logic rst_now;
        e = '{fwd: fwd, stall: st, cause: cause, busy: busy, done: done, cnt: exp_cnt};
        exp_q.push_back(e);
        name_q.push_back(nm);
        rst_now = rst;
        @(posedge clk); #1;
        if (rst_now)
            exp_cnt = '0;
        else if (st && exp_cnt != 4'hF)
            exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic set_load_use();
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteRegister = 5'd7;
        ID_src_valid = 2'b10; ID_src_addr = {5'd7, 5'd0};
    endtask

    initial begin
        do_reset();
        cyc("reset", 4'b0000, 0, 2'b00, 0, 0);

        // Forwarding
        MEM_RegWrite = 1; MEM_WriteRegister = 5'd5; WB_RegWrite = 1; WB_WriteRegister = 5'd5;
        EX_src_addr = {5'd0, 5'd5};
        cyc("fwd_mem_over_wb", 4'b0010, 0, 2'b00, 0, 0);
        MEM_RegWrite = 0;
        cyc("fwd_wb_only", 4'b0001, 0, 2'b00, 0, 0);
        MEM_RegWrite = 1; MEM_WriteRegister = 5'd0; WB_WriteRegister = 5'd0;
        EX_src_addr = {5'd0, 5'd0};
        cyc("fwd_r0", 4'b0000, 0, 2'b00, 0, 0);
        MEM_WriteRegister = 5'd3; WB_WriteRegister = 5'd4; EX_src_addr = {5'd3, 5'd4};
        cyc("fwd_two_slots", 4'b1001, 0, 2'b00, 0, 0);
        idle();

        // Load-use
        set_load_use();
        cyc("load_use", 4'b0000, 1, 2'b01, 0, 0);
        ID_src_valid = 2'b00;
        cyc("load_use_invalid_src", 4'b0000, 0, 2'b00, 0, 0);
        set_load_use(); EX_MemRead = 0;
        cyc("not_a_load", 4'b0000, 0, 2'b00, 0, 0);
        set_load_use(); EX_WriteRegister = 5'd0; ID_src_addr = {5'd0, 5'd0};
        cyc("load_to_r0", 4'b0000, 0, 2'b00, 0, 0);
        set_load_use(); ID_mul_valid = 1; ID_mul_dst = 5'd9;
        cyc("blocked_issue", 4'b0000, 1, 2'b01, 0, 0);
        EX_MemRead = 0; ID_src_valid = 2'b00;
        cyc("retry_issue", 4'b0000, 0, 2'b00, 0, 0);
        idle();
        cyc("retry_busy", 4'b0000, 0, 2'b00, 1, 0);

        // RAW on pending multi-cycle destination
        do_reset();
        ID_mul_valid = 1; ID_mul_dst = 5'd9;
        cyc("raw_issue", 4'b0000, 0, 2'b00, 0, 0);
        ID_mul_valid = 0; ID_src_valid = 2'b01; ID_src_addr = {5'd0, 5'd9};
        repeat (4) cyc("raw_pending", 4'b0000, 1, 2'b10, 1, 0);
        cyc("raw_release", 4'b0000, 0, 2'b00, 0, 1);
        idle();
        cyc("raw_after_done", 4'b0000, 0, 2'b00, 0, 0);

        // Structural, back-to-back issue through DONE
        do_reset();
        ID_mul_valid = 1; ID_mul_dst = 5'd9;
        cyc("st_issue", 4'b0000, 0, 2'b00, 0, 0);
        ID_mul_dst = 5'd3; ID_src_valid = 2'b01; ID_src_addr = {5'd0, 5'd9};
        cyc("raw_over_struct", 4'b0000, 1, 2'b10, 1, 0);
        ID_src_valid = 2'b00;
        repeat (3) cyc("struct", 4'b0000, 1, 2'b11, 1, 0);
        cyc("second_accept", 4'b0000, 0, 2'b00, 0, 1);
        idle(); ID_src_valid = 2'b01; ID_src_addr = {5'd0, 5'd9};
        cyc("old_dst_free", 4'b0000, 0, 2'b00, 1, 0);
        ID_src_addr = {5'd0, 5'd3};
        cyc("new_dst_raw", 4'b0000, 1, 2'b10, 1, 0);
        idle();
        repeat (2) cyc("second_busy", 4'b0000, 0, 2'b00, 1, 0);
        cyc("second_done", 4'b0000, 0, 2'b00, 0, 1);
        cyc("second_idle", 4'b0000, 0, 2'b00, 0, 0);

        // dst = 0 never interlocks
        do_reset();
        ID_mul_valid = 1; ID_mul_dst = 5'd0;
        cyc("dst0_issue", 4'b0000, 0, 2'b00, 0, 0);
        ID_mul_valid = 0; ID_src_valid = 2'b11; ID_src_addr = {5'd0, 5'd0};
        cyc("dst0_no_raw", 4'b0000, 0, 2'b00, 1, 0);

        // Reset during BUSY
        do_reset();
        ID_mul_valid = 1; ID_mul_dst = 5'd9;
        cyc("rb_issue", 4'b0000, 0, 2'b00, 0, 0);
        idle();
        cyc("rb_busy", 4'b0000, 0, 2'b00, 1, 0);
        rst = 1; ID_src_valid = 2'b01; ID_src_addr = {5'd0, 5'd9};
        cyc("rb_reset_cycle", 4'b0000, 1, 2'b10, 1, 0);
        rst = 0;
        repeat (5) cyc("rb_after_reset", 4'b0000, 0, 2'b00, 0, 0);

        // Counter saturation
        do_reset();
        set_load_use();
        repeat (20) cyc("sat_stall", 4'b0000, 1, 2'b01, 0, 0);
        idle();
        cyc("sat_hold", 4'b0000, 0, 2'b00, 0, 0);

        @(posedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
